// File: rtl/gf180mcu_ocd_io_pwr_seq.sv
// Pad-ring supply sequencer: ramps NDOM supply domains up in index order,
// each gated on its debounced power-good, and down in reverse order.
module gf180mcu_ocd_io_pwr_seq #(
    parameter int NDOM    = 3,
    parameter int DEB     = 4,
    parameter int TIMEOUT = 64,
    parameter int OFF_DLY = 8,
    parameter int IDXW    = (NDOM > 1) ? $clog2(NDOM) : 1
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            PWR_REQ,
    input  logic [NDOM-1:0] PG,
    input  logic            CLR_FAULT,
    output logic [NDOM-1:0] EN,
    output logic            PWR_OK,
    output logic            BUSY,
    output logic            FAULT,
    output logic [IDXW-1:0] FAULT_DOM
);

    localparam int TMAX = (TIMEOUT > OFF_DLY) ? TIMEOUT : OFF_DLY;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(DEB + 1);

    localparam logic [TW-1:0]   T_TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_OFF_LAST     = TW'(OFF_DLY - 1);
    localparam logic [DW-1:0]   D_LAST         = DW'(DEB - 1);
    localparam logic [IDXW-1:0] LAST_IDX       = IDXW'(NDOM - 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP,
        ST_ON,
        ST_DOWN,
        ST_FAULT
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic [TW-1:0]   r_tmr;
    logic [DW-1:0]   r_deb;
    logic [NDOM-1:0] r_pgMeta;
    logic [NDOM-1:0] r_pgSync;
    logic [NDOM-1:0] r_en;
    logic            r_pwrOk;
    logic            r_busy;
    logic            r_fault;
    logic [IDXW-1:0] r_faultDom;

    logic            w_lowAny;
    logic [IDXW-1:0] w_lowIdx;
    logic            w_lostAny;
    logic [IDXW-1:0] w_lostIdx;
    logic            w_accept;
    logic            w_timeout;
    logic [IDXW-1:0] w_nextIdx;
    logic [IDXW-1:0] w_prevIdx;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_pgMeta <= '0;
            r_pgSync <= '0;
        end else begin
            r_pgMeta <= PG;
            r_pgSync <= r_pgMeta;
        end
    end

    // Lowest domain whose synchronized PG is low, overall and among accepted ones.
    always_comb begin
        w_lowAny  = 1'b0;
        w_lowIdx  = '0;
        w_lostAny = 1'b0;
        w_lostIdx = '0;
        for (int i = NDOM - 1; i >= 0; i--) begin
            if (!r_pgSync[i]) begin
                w_lowAny = 1'b1;
                w_lowIdx = IDXW'(i);
                if (IDXW'(i) < r_idx) begin
                    w_lostAny = 1'b1;
                    w_lostIdx = IDXW'(i);
                end
            end
        end
    end

    assign w_accept  = r_pgSync[r_idx] && (r_deb == D_LAST);
    assign w_timeout = (r_tmr == T_TIMEOUT_LAST);
    assign w_nextIdx = r_idx + IDXW'(1);
    assign w_prevIdx = r_idx - IDXW'(1);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state    <= ST_OFF;
            r_idx      <= '0;
            r_tmr      <= '0;
            r_deb      <= '0;
            r_en       <= '0;
            r_pwrOk    <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_faultDom <= '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_tmr <= '0;
                    r_deb <= '0;
                    if (PWR_REQ) begin
                        r_state <= ST_RAMP;
                        r_idx   <= '0;
                        r_en    <= NDOM'(1);
                        r_busy  <= 1'b1;
                    end
                end

                // Accept wins over an expiring timer on the same edge.
                ST_RAMP: begin
                    if (w_lostAny || (!w_accept && w_timeout)) begin
                        r_state    <= ST_FAULT;
                        r_en       <= '0;
                        r_pwrOk    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_fault    <= 1'b1;
                        r_faultDom <= w_lostAny ? w_lostIdx : r_idx;
                        r_tmr      <= '0;
                        r_deb      <= '0;
                    end else if (!PWR_REQ) begin
                        r_state      <= ST_DOWN;
                        r_en[r_idx]  <= 1'b0;
                        r_tmr        <= '0;
                        r_deb        <= '0;
                    end else if (w_accept) begin
                        r_tmr <= '0;
                        r_deb <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_ON;
                            r_pwrOk <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx           <= w_nextIdx;
                            r_en[w_nextIdx] <= 1'b1;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                        r_deb <= r_pgSync[r_idx] ? r_deb + DW'(1) : '0;
                    end
                end

                ST_ON: begin
                    if (w_lowAny) begin
                        r_state    <= ST_FAULT;
                        r_en       <= '0;
                        r_pwrOk    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_fault    <= 1'b1;
                        r_faultDom <= w_lowIdx;
                    end else if (!PWR_REQ) begin
                        r_state     <= ST_DOWN;
                        r_en[r_idx] <= 1'b0;
                        r_pwrOk     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_tmr       <= '0;
                    end
                end

                // EN[idx] is already low; after OFF_DLY edges drop the next one down.
                ST_DOWN: begin
                    if (r_tmr == T_OFF_LAST) begin
                        r_tmr <= '0;
                        if (r_idx == '0) begin
                            r_state <= ST_OFF;
                            r_busy  <= 1'b0;
                        end else begin
                            r_en[w_prevIdx] <= 1'b0;
                            r_idx           <= w_prevIdx;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end

                ST_FAULT: begin
                    if (CLR_FAULT && !PWR_REQ) begin
                        r_state    <= ST_OFF;
                        r_fault    <= 1'b0;
                        r_faultDom <= '0;
                        r_idx      <= '0;
                    end
                end

                default: begin
                    r_state <= ST_OFF;
                    r_en    <= '0;
                    r_pwrOk <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign EN        = r_en;
    assign PWR_OK    = r_pwrOk;
    assign BUSY      = r_busy;
    assign FAULT     = r_fault;
    assign FAULT_DOM = r_faultDom;

endmodule

// File: tb/tb_gf180mcu_ocd_io_pwr_seq.sv
// Directed bench for the pad-ring supply sequencer; PG follows EN unless a
// domain is forced low through pgKill.
module tb_gf180mcu_ocd_io_pwr_seq;

    logic       CLK;
    logic       RN;
    logic       PWR_REQ;
    logic       CLR_FAULT;
    logic [2:0] PG;
    logic [2:0] EN;
    logic [2:0] pgKill;
    logic       PWR_OK;
    logic       BUSY;
    logic       FAULT;
    logic [1:0] FAULT_DOM;

    int checks   = 0;
    int failures = 0;

    assign PG = EN & ~pgKill;

    gf180mcu_ocd_io_pwr_seq #(
        .NDOM    (3),
        .DEB     (4),
        .TIMEOUT (64),
        .OFF_DLY (8)
    ) dut (
        .CLK       (CLK),
        .RN        (RN),
        .PWR_REQ   (PWR_REQ),
        .PG        (PG),
        .CLR_FAULT (CLR_FAULT),
        .EN        (EN),
        .PWR_OK    (PWR_OK),
        .BUSY      (BUSY),
        .FAULT     (FAULT),
        .FAULT_DOM (FAULT_DOM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic req, input logic clr);
        PWR_REQ   = req;
        CLR_FAULT = clr;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        RN     = 1'b0;
        pgKill = 3'b000;
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("rst_en", 32'(EN), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_pwrok", 32'(PWR_OK), 32'd0);
        checkOutput("rst_fault", 32'(FAULT), 32'd0);
        checkOutput("rst_fdom", 32'(FAULT_DOM), 32'd0);
        waitEdges(2);
        RN = 1'b1;
        waitEdges(2);
        checkOutput("idle_en", 32'(EN), 32'd0);

        // Power-up ramp with PG following EN.
        $display("[TB] ramp-up");
        applyStimulus(1'b1, 1'b0);
        waitEdges(1);
        checkOutput("t1_en_e0", 32'(EN), 32'd1);
        checkOutput("t1_busy_e0", 32'(BUSY), 32'd1);
        waitEdges(5);
        checkOutput("t1_en_e5", 32'(EN), 32'd1);
        waitEdges(1);
        checkOutput("t1_en_e6", 32'(EN), 32'd3);
        waitEdges(5);
        checkOutput("t1_en_e11", 32'(EN), 32'd3);
        waitEdges(1);
        checkOutput("t1_en_e12", 32'(EN), 32'd7);
        waitEdges(5);
        checkOutput("t1_pwrok_e17", 32'(PWR_OK), 32'd0);
        checkOutput("t1_busy_e17", 32'(BUSY), 32'd1);
        waitEdges(1);
        checkOutput("t1_pwrok_e18", 32'(PWR_OK), 32'd1);
        checkOutput("t1_busy_e18", 32'(BUSY), 32'd0);
        checkOutput("t1_en_e18", 32'(EN), 32'd7);

        // Orderly shutdown from ON.
        $display("[TB] shutdown");
        applyStimulus(1'b0, 1'b0);
        waitEdges(1);
        checkOutput("t2_pwrok_f0", 32'(PWR_OK), 32'd0);
        checkOutput("t2_en_f0", 32'(EN), 32'd3);
        checkOutput("t2_busy_f0", 32'(BUSY), 32'd1);
        waitEdges(7);
        checkOutput("t2_en_f7", 32'(EN), 32'd3);
        waitEdges(1);
        checkOutput("t2_en_f8", 32'(EN), 32'd1);
        waitEdges(8);
        checkOutput("t2_en_f16", 32'(EN), 32'd0);
        waitEdges(7);
        checkOutput("t2_busy_f23", 32'(BUSY), 32'd1);
        waitEdges(1);
        checkOutput("t2_busy_f24", 32'(BUSY), 32'd0);

        // Domain 1 never reports good: timeout fault, then clear handshake.
        $display("[TB] timeout fault");
        pgKill = 3'b010;
        applyStimulus(1'b1, 1'b0);
        waitEdges(1);
        checkOutput("t3_en_e0", 32'(EN), 32'd1);
        waitEdges(6);
        checkOutput("t3_en_a0", 32'(EN), 32'd3);
        waitEdges(63);
        checkOutput("t3_fault_a63", 32'(FAULT), 32'd0);
        checkOutput("t3_en_a63", 32'(EN), 32'd3);
        waitEdges(1);
        checkOutput("t3_fault_a64", 32'(FAULT), 32'd1);
        checkOutput("t3_fdom_a64", 32'(FAULT_DOM), 32'd1);
        checkOutput("t3_en_a64", 32'(EN), 32'd0);
        checkOutput("t3_busy_a64", 32'(BUSY), 32'd0);
        applyStimulus(1'b1, 1'b1);
        waitEdges(2);
        checkOutput("t3_clr_req1_fault", 32'(FAULT), 32'd1);
        checkOutput("t3_clr_req1_en", 32'(EN), 32'd0);
        applyStimulus(1'b0, 1'b1);
        waitEdges(1);
        checkOutput("t3_clr_fault", 32'(FAULT), 32'd0);
        checkOutput("t3_clr_fdom", 32'(FAULT_DOM), 32'd0);
        applyStimulus(1'b0, 1'b0);
        pgKill = 3'b000;
        waitEdges(2);
        checkOutput("t3_off_en", 32'(EN), 32'd0);

        // Glitch on PG[2] while ON.
        $display("[TB] PG loss in ON");
        applyStimulus(1'b1, 1'b0);
        waitEdges(1);
        checkOutput("t4_en_e0", 32'(EN), 32'd1);
        waitEdges(18);
        checkOutput("t4_pwrok_on", 32'(PWR_OK), 32'd1);
        pgKill = 3'b100;
        waitEdges(2);
        checkOutput("t4_fault_g2", 32'(FAULT), 32'd0);
        checkOutput("t4_en_g2", 32'(EN), 32'd7);
        waitEdges(1);
        checkOutput("t4_fault_g3", 32'(FAULT), 32'd1);
        checkOutput("t4_fdom_g3", 32'(FAULT_DOM), 32'd2);
        checkOutput("t4_en_g3", 32'(EN), 32'd0);
        checkOutput("t4_pwrok_g3", 32'(PWR_OK), 32'd0);
        pgKill = 3'b000;
        applyStimulus(1'b0, 1'b1);
        waitEdges(1);
        checkOutput("t4_clr_fault", 32'(FAULT), 32'd0);
        applyStimulus(1'b0, 1'b0);
        waitEdges(1);

        // Request drops mid-ramp; a request pulse during DOWN is ignored.
        $display("[TB] abort during ramp");
        applyStimulus(1'b1, 1'b0);
        waitEdges(7);
        checkOutput("t5_en_e6", 32'(EN), 32'd3);
        applyStimulus(1'b0, 1'b0);
        waitEdges(1);
        checkOutput("t5_en_h0", 32'(EN), 32'd1);
        checkOutput("t5_busy_h0", 32'(BUSY), 32'd1);
        waitEdges(7);
        checkOutput("t5_en_h7", 32'(EN), 32'd1);
        waitEdges(1);
        checkOutput("t5_en_h8", 32'(EN), 32'd0);
        waitEdges(1);
        applyStimulus(1'b1, 1'b0);
        waitEdges(1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_en_h10", 32'(EN), 32'd0);
        checkOutput("t5_busy_h10", 32'(BUSY), 32'd1);
        waitEdges(5);
        checkOutput("t5_busy_h15", 32'(BUSY), 32'd1);
        waitEdges(1);
        checkOutput("t5_busy_h16", 32'(BUSY), 32'd0);
        waitEdges(1);
        checkOutput("t5_en_h17", 32'(EN), 32'd0);
        checkOutput("t5_busy_h17", 32'(BUSY), 32'd0);

        // Asynchronous reset mid-ramp.
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0);
        waitEdges(7);
        checkOutput("t6_en_pre", 32'(EN), 32'd3);
        #2;
        RN = 1'b0;
        #1;
        checkOutput("t6_en_async", 32'(EN), 32'd0);
        checkOutput("t6_busy_async", 32'(BUSY), 32'd0);
        checkOutput("t6_pwrok_async", 32'(PWR_OK), 32'd0);
        waitEdges(2);
        RN = 1'b1;
        waitEdges(1);
        checkOutput("t6_en_r0", 32'(EN), 32'd1);
        checkOutput("t6_busy_r0", 32'(BUSY), 32'd1);
        waitEdges(6);
        checkOutput("t6_en_r6", 32'(EN), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
